// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: writeback-mux select encodings
// and the arbiter FSM state type.
package wb_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_CSR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Load-response timeout counter: cleared when a load is accepted, counts waiting
// cycles, and flags expiry on the last permitted waiting cycle.
module wb_timeout_counter #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + W'(1);
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges zero-latency ALU/PC4/CSR results with one outstanding
// variable-latency load. Optional perf counters are enabled by WB_ARBITER_PERF_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [4:0]  pipe_rs1,
    input  logic [4:0]  pipe_rs2,
    input  logic [1:0]  pipe_wb_sel,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [1:0]  wb_sel,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        load_busy,
    output logic        load_fault,
    output logic [1:0]  dbg_state
`ifdef WB_ARBITER_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] load_count
`endif
);

    wb_state_e   r_state;
    wb_state_e   w_next_state;
    logic [4:0]  r_pending_rd;
    logic [31:0] r_load_data;
    logic        r_load_fault;
    logic        w_accept;
    logic        w_hazard;
    logic        w_expired;
    logic        w_cnt_en;

    // Any reference to the pending destination (RAW or WAW) must wait for the load.
    assign w_hazard = (r_pending_rd != 5'd0) &&
                      ((pipe_rs1 == r_pending_rd) ||
                       (pipe_rs2 == r_pending_rd) ||
                       (pipe_rd  == r_pending_rd));

    assign w_cnt_en = (r_state == WAIT) && !mem_rvalid && !w_expired;

    wb_timeout_counter #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_accept),
        .enable  (w_cnt_en),
        .expired (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = pipe_rd;
        wb_sel       = pipe_wb_sel;
        stall        = 1'b0;
        case (r_state)
            IDLE: begin
                if (pipe_valid) begin
                    if (pipe_wb_sel == WB_MEM) begin
                        w_accept     = 1'b1;
                        w_next_state = WAIT;
                    end else begin
                        rf_we = (pipe_rd != 5'd0);
                    end
                end
            end
            WAIT: begin
                if (pipe_valid) begin
                    if ((pipe_wb_sel == WB_MEM) || w_hazard) begin
                        stall = 1'b1;
                    end else begin
                        rf_we = (pipe_rd != 5'd0);
                    end
                end
                // A response arriving in the expiry cycle still completes the load.
                if (mem_rvalid) begin
                    w_next_state = WRITE;
                end else if (w_expired) begin
                    w_next_state = IDLE;
                end
            end
            WRITE: begin
                rf_we        = (r_pending_rd != 5'd0);
                rf_waddr     = r_pending_rd;
                wb_sel       = WB_MEM;
                stall        = pipe_valid;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pending_rd <= 5'd0;
            r_load_data  <= 32'd0;
            r_load_fault <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_load_fault <= (r_state == WAIT) && !mem_rvalid && w_expired;
            if (w_accept) begin
                r_pending_rd <= pipe_rd;
            end
            if ((r_state == WAIT) && mem_rvalid) begin
                r_load_data <= mem_rdata;
            end
        end
    end

    assign load_data  = r_load_data;
    assign load_fault = r_load_fault;
    assign load_busy  = (r_state != IDLE);
    assign dbg_state  = r_state;

`ifdef WB_ARBITER_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_load_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_load_count   <= 32'd0;
        end else begin
            if (stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_accept) begin
                r_load_count <= r_load_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign load_count   = r_load_count;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed vectors, a transaction-level model checked
// every cycle, and literal expectations at key points of each scenario.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [4:0]  pipe_rs1;
    logic [4:0]  pipe_rs2;
    logic [1:0]  pipe_wb_sel;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [1:0]  wb_sel;
    logic [31:0] load_data;
    logic        stall;
    logic        load_busy;
    logic        load_fault;
    logic [1:0]  dbg_state;
`ifdef WB_ARBITER_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] load_count;
    logic [31:0] lc_before;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter #(
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_valid  (pipe_valid),
        .pipe_rd     (pipe_rd),
        .pipe_rs1    (pipe_rs1),
        .pipe_rs2    (pipe_rs2),
        .pipe_wb_sel (pipe_wb_sel),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .wb_sel      (wb_sel),
        .load_data   (load_data),
        .stall       (stall),
        .load_busy   (load_busy),
        .load_fault  (load_fault),
        .dbg_state   (dbg_state)
`ifdef WB_ARBITER_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .load_count   (load_count)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // m_out: load outstanding awaiting data; m_wr: data arrived, this is the write cycle.
    bit          m_out, m_wr, m_fault;
    int          m_waited;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int unsigned m_stalls, m_loads;
    logic        e_we, e_stall, e_acc;
    logic [4:0]  e_waddr;
    logic [1:0]  e_sel;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            if (!pipe_valid) begin
                check("rst_rf_we", rf_we, 0);
                check("rst_stall", stall, 0);
            end
            check("rst_busy", load_busy, 0);
            check("rst_fault", load_fault, 0);
            check("rst_load_data", load_data, 0);
            m_out = 0; m_wr = 0; m_fault = 0; m_waited = 0;
            m_rd = 0; m_data = 0; m_stalls = 0; m_loads = 0;
        end else begin
            e_we = 0; e_stall = 0; e_acc = 0;
            e_waddr = pipe_rd; e_sel = pipe_wb_sel;
            if (m_wr) begin
                e_we = (m_rd != 0); e_waddr = m_rd; e_sel = WB_MEM; e_stall = pipe_valid;
            end else if (m_out) begin
                if (pipe_valid) begin
                    if (pipe_wb_sel == WB_MEM ||
                        (m_rd != 0 && (pipe_rs1 == m_rd || pipe_rs2 == m_rd || pipe_rd == m_rd)))
                        e_stall = 1;
                    else
                        e_we = (pipe_rd != 0);
                end
            end else if (pipe_valid) begin
                if (pipe_wb_sel == WB_MEM) e_acc = 1;
                else e_we = (pipe_rd != 0);
            end

            check("rf_we", rf_we, e_we);
            check("stall", stall, e_stall);
            check("load_busy", load_busy, m_out || m_wr);
            check("load_fault", load_fault, m_fault);
            check("load_data", load_data, m_data);
            if (e_we) check("rf_waddr", rf_waddr, e_waddr);
            if (pipe_valid || m_wr) check("wb_sel", wb_sel, e_sel);
`ifdef WB_ARBITER_PERF_EN
            check("stall_cycles", stall_cycles, m_stalls);
            check("load_count", load_count, m_loads);
`endif
            // Advance the model to the state after the coming clock edge.
            m_stalls += e_stall;
            m_fault = 0;
            if (m_wr) begin
                m_wr = 0;
            end else if (m_out) begin
                if (mem_rvalid) begin
                    m_data = mem_rdata; m_wr = 1; m_out = 0;
                end else if (m_waited == TO - 1) begin
                    m_out = 0; m_fault = 1;
                end else begin
                    m_waited++;
                end
            end else if (e_acc) begin
                m_out = 1; m_waited = 0; m_rd = pipe_rd; m_loads++;
            end
        end
    end

    // ---------------- driver ----------------
    // Inputs change on the falling edge; literal checks run 3 time units later.
    task automatic step(input logic v, input logic [1:0] sel, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic rv, input logic [31:0] rdata);
        @(negedge clk);
        pipe_valid = v; pipe_wb_sel = sel; pipe_rd = rd;
        pipe_rs1 = rs1; pipe_rs2 = rs2;
        mem_rvalid = rv; mem_rdata = rdata;
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, WB_ALU, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic resp(input logic [31:0] d);
        step(0, WB_ALU, 0, 0, 0, 1, d);
    endtask

    task automatic load(input logic [4:0] rd);
        step(1, WB_MEM, rd, 0, 0, 0, 32'h0);
    endtask

    initial begin
        rst = 1; pipe_valid = 0; pipe_rd = 0; pipe_rs1 = 0; pipe_rs2 = 0;
        pipe_wb_sel = WB_ALU; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        #3;
        check("lit_rst_busy", load_busy, 0);
        check("lit_rst_we", rf_we, 0);
        check("lit_rst_dbg_state", dbg_state, 0);
        @(negedge clk);
        rst = 0;

        // ALU op, zero latency
        step(1, WB_ALU, 5, 1, 2, 0, 0);
        check("lit_alu_we", rf_we, 1);
        check("lit_alu_waddr", rf_waddr, 5);
        check("lit_alu_sel", wb_sel, 0);
        check("lit_alu_stall", stall, 0);

        // load rd=7, response three cycles after acceptance; rvalid in WRITE ignored
        load(7);
        check("lit_ld_accept_we", rf_we, 0);
        check("lit_ld_accept_stall", stall, 0);
        idle(2);
        resp(32'hDEADBEEF);
        check("lit_ld_wait_busy", load_busy, 1);
        resp(32'h11111111);
        check("lit_ld_write_we", rf_we, 1);
        check("lit_ld_write_waddr", rf_waddr, 7);
        check("lit_ld_write_sel", wb_sel, 1);
        check("lit_ld_write_data", load_data, 32'hDEADBEEF);
        idle(1);
        check("lit_ld_done_busy", load_busy, 0);
        check("lit_ld_rvalid_in_write_ignored", load_data, 32'hDEADBEEF);

        // RAW hazard on pending load, then independent op during a load
`ifdef WB_ARBITER_PERF_EN
        lc_before = load_count;
`endif
        load(7);
        step(1, WB_ALU, 9, 7, 2, 0, 0);
        check("lit_raw_stall", stall, 1);
        check("lit_raw_we", rf_we, 0);
        step(1, WB_ALU, 9, 7, 2, 0, 0);
        step(1, WB_ALU, 9, 7, 2, 1, 32'h00001234);
        check("lit_raw_stall_rvalid", stall, 1);
        step(1, WB_ALU, 9, 7, 2, 0, 0);
        check("lit_raw_write_stall", stall, 1);
        check("lit_raw_write_waddr", rf_waddr, 7);
        step(1, WB_ALU, 9, 7, 2, 0, 0);
        check("lit_raw_release_stall", stall, 0);
        check("lit_raw_release_waddr", rf_waddr, 9);
`ifdef WB_ARBITER_PERF_EN
        check("lit_perf_load_delta", load_count - lc_before, 1);
`endif
        load(7);
        step(1, WB_ALU, 4, 3, 5, 0, 0);
        check("lit_indep_stall", stall, 0);
        check("lit_indep_we", rf_we, 1);
        check("lit_indep_waddr", rf_waddr, 4);
        resp(32'hCAFE0001);
        idle(1);

        // WAW on pending rd, and a second load behind an outstanding one
        load(8);
        step(1, WB_CSR, 8, 1, 2, 0, 0);
        check("lit_waw_stall", stall, 1);
        resp(32'h8);
        idle(1);
        load(3);
        load(4);
        check("lit_load2_stall", stall, 1);
        step(1, WB_MEM, 4, 0, 0, 1, 32'h3333);
        load(4);
        check("lit_load2_write_stall", stall, 1);
        load(4);
        check("lit_load2_accept_stall", stall, 0);
        resp(32'h4444);
        idle(1);

        // timeout: four waiting cycles without response
        load(10);
        idle(TO);
        idle(1);
        check("lit_to_fault", load_fault, 1);
        check("lit_to_busy", load_busy, 0);
        check("lit_to_we", rf_we, 0);
        idle(1);
        check("lit_to_fault_pulse", load_fault, 0);

        // response in the final waiting cycle wins over timeout
        load(10);
        idle(TO - 1);
        resp(32'hAAAA5555);
        idle(1);
        check("lit_late_we", rf_we, 1);
        check("lit_late_waddr", rf_waddr, 10);
        check("lit_late_fault", load_fault, 0);
        idle(1);
        check("lit_late_fault_after", load_fault, 0);

        // load to x0 never writes
        load(0);
        resp(32'h0BAD0BAD);
        idle(1);
        check("lit_x0_we", rf_we, 0);
        check("lit_x0_busy", load_busy, 1);
        idle(1);

        // reset during WAIT abandons the load; later rvalid is ignored
        load(6);
        idle(1);
        @(negedge clk);
        rst = 1;
        #3;
        check("lit_rstw_busy", load_busy, 0);
        check("lit_rstw_fault", load_fault, 0);
        @(negedge clk);
        rst = 0;
        resp(32'hFFFFFFFF);
        check("lit_rstw_rvalid_we", rf_we, 0);
        idle(1);
        check("lit_rstw_after_busy", load_busy, 0);
        check("lit_rstw_after_data", load_data, 0);
        check("lit_rstw_after_fault", load_fault, 0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
